// File: rtl/deinterleaver.sv
// deinterleaver: serial-in block deinterleaver for (n,k) Hamming codewords.
// Define DEINTERLEAVER_PINGPONG_EN for two-bank (fill while presenting) mode.
`timescale 1ns/1ps
module deinterleaver #(
  parameter int n          = 7,
  parameter int symbol_num = 5,
  localparam int L  = n * symbol_num,
  localparam int CW = $clog2(L + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          in_valid,
  input  logic          in_bit,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [L-1:0]  data_o,
  output logic [CW-1:0] fill_cnt
);

  typedef enum logic {FILL, FULL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [L-1:0]    buf_q, buf_d;
  logic [L-1:0]    out_q, out_d;
  logic            ov_q, ov_d;
  logic            live_q;
  logic            acc, hs, wr, done;

  function automatic logic [L-1:0] perm(input logic [L-1:0] b);
    logic [L-1:0] r;
    r = '0;
    for (int a = 0; a < symbol_num; a++)
      for (int j = 0; j < n; j++)
        r[a*n+j] = b[j*symbol_num+a];
    return r;
  endfunction

  // input side: a held FULL block blocks filling until it can be presented
`ifdef DEINTERLEAVER_PINGPONG_EN
  assign in_ready = live_q && en && !(ov_q && state_q == FULL);
`else
  assign in_ready = live_q && en && !ov_q;
`endif

  assign out_valid = ov_q;
  assign data_o    = out_q;
  assign fill_cnt  = cnt_q;

  // fill, completion and output-handoff next state
  always_comb begin
    acc     = in_valid && in_ready;
    hs      = ov_q && out_ready;
    wr      = acc && !clr;
    done    = wr && (cnt_q == CW'(L - 1));
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    out_d   = out_q;
    ov_d    = ov_q;

    if (wr)
      for (int i = 0; i < L; i++)
        if (cnt_q == CW'(i)) buf_d[i] = in_bit;

    if (clr)       cnt_d = '0;
    else if (done) cnt_d = '0;
    else if (wr)   cnt_d = cnt_q + CW'(1);

    if (hs) begin
      if (state_q == FULL) begin
        out_d   = perm(buf_q);
        state_d = FILL;
      end else if (done) begin
        out_d = perm(buf_d);
      end else begin
        ov_d = 1'b0;
      end
    end else if (done) begin
      if (ov_q) begin
        state_d = FULL;
      end else begin
        out_d = perm(buf_d);
        ov_d  = 1'b1;
      end
    end
  end

  // state registers; live_q keeps in_ready low until the first edge out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      buf_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_deinterleaver.sv
// tb_deinterleaver: random stream checked against a queue-based block model.
// Build with DEINTERLEAVER_PINGPONG_EN to check the two-bank mode.
`timescale 1ns/1ps
module tb_deinterleaver;
  localparam int N  = 7;
  localparam int SN = 5;
  localparam int L  = N * SN;
  localparam int CW = $clog2(L + 1);
`ifdef DEINTERLEAVER_PINGPONG_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 0, rst = 1, en = 0, clr = 0;
  logic in_valid = 0, in_bit = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [L-1:0]  data_o;
  logic [CW-1:0] fill_cnt;

  deinterleaver #(.n(N), .symbol_num(SN)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_o(data_o), .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  bit live_m = 0;
  bit bitq_m[$];
  logic [L-1:0] blk_m[$];
  logic [L-1:0] last_m = '0;
  logic [L-1:0] lb_q[$];
  bit lb_on = 0;

  logic [L-1:0] dw, iw, bv;
  bit v, e, r, will;
  int guard;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [L-1:0] deint(input logic [L-1:0] s);
    logic [L-1:0] o;
    o = '0;
    for (int a = 0; a < SN; a++)
      for (int b = 0; b < N; b++)
        o[a*N+b] = s[b*SN+a];
    return o;
  endfunction

  function automatic logic [L-1:0] ilv(input logic [L-1:0] d);
    logic [L-1:0] o;
    o = '0;
    for (int a = 0; a < SN; a++)
      for (int b = 0; b < N; b++)
        o[b*SN+a] = d[a*N+b];
    return o;
  endfunction

  function automatic bit pred_rdy(input bit en_v);
    return live_m && en_v && (blk_m.size() < CAP);
  endfunction

  task automatic step(input bit vv, input bit bb, input bit rr,
                      input bit ee, input bit cc);
    bit rdy, hs, acc;
    logic [L-1:0] s;
    in_valid = vv; in_bit = bb; out_ready = rr; en = ee; clr = cc;
    #1;
    rdy = pred_rdy(ee);
    check("in_ready", in_ready, rdy);
    hs  = (blk_m.size() > 0) && rr;
    acc = vv && rdy;
    if (hs && lb_on && lb_q.size() > 0)
      check("loopback", data_o, lb_q.pop_front());
    @(posedge clk);
    if (hs) void'(blk_m.pop_front());
    if (cc) bitq_m.delete();
    else if (acc) begin
      bitq_m.push_back(bb);
      if (bitq_m.size() == L) begin
        for (int k = 0; k < L; k++) s[k] = bitq_m[k];
        blk_m.push_back(deint(s));
        bitq_m.delete();
      end
    end
    if (blk_m.size() > 0) last_m = blk_m[0];
    live_m = 1;
    @(negedge clk);
    check("out_valid", out_valid, blk_m.size() > 0);
    check("data_o", data_o, last_m);
    check("fill_cnt", fill_cnt, bitq_m.size());
  endtask

  task automatic drain();
    for (int k = 0; k < 6; k++) step(0, 0, 1, 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; en = 1; in_valid = 1;
    repeat (2) @(negedge clk);
    check("rst_fill", fill_cnt, 0);
    check("rst_ov", out_valid, 0);
    check("rst_data", data_o, 0);
    check("rst_rdy", in_ready, 0);
    rst = 0; in_valid = 0;
    step(0, 0, 0, 1, 0);

    for (int k = 0; k < L; k++) step(1, k == 5, 0, 1, 0);
    check("t028_data", data_o, 35'h2);
    check("t028_ov", out_valid, 1);
    check("t028_fill", fill_cnt, 0);

    for (int k = 0; k < 40; k++) step(1, 1'($urandom), 0, 1, 0);
    check("t030_data", data_o, 35'h2);
    drain();

    lb_on = 1;
    for (int blk = 0; blk <= 100; blk++) begin
      dw = (blk == 0) ? 35'h5A5A5A5A5 : L'({$urandom, $urandom});
      lb_q.push_back(dw);
      iw = ilv(dw);
      for (int k = 0; k < L; k++) begin
        guard = 0;
        do begin
          v = $urandom_range(0, 3) != 0;
          e = $urandom_range(0, 9) != 0;
          r = $urandom_range(0, 1);
          will = v && pred_rdy(e);
          step(v, iw[k], r, e, 0);
          guard++;
        end while (!will && guard < 500);
        if (!will) check("lb_stall", 1, 0);
      end
    end
    drain();
    lb_on = 0;

    for (int k = 0; k < 17; k++) step(1, 1'($urandom), 0, 1, 0);
    step(1, 1, 0, 1, 1);
    check("t031_fill", fill_cnt, 0);
    check("t031_ov", out_valid, 0);
    bv = L'({$urandom, $urandom});
    for (int k = 0; k < L; k++) step(1, bv[k], 0, 1, 0);
    check("t031_blk", data_o, deint(bv));
    drain();

    for (int k = 0; k < 10; k++) step(1, 1'($urandom), 0, 1, 0);
    for (int k = 0; k < 10; k++) step(1, 1'($urandom), 0, 0, 0);
    check("t032_fill", fill_cnt, 10);
    for (int k = 0; k < 25; k++) step(1, 1'($urandom), 0, 1, 0);
    for (int k = 0; k < 5; k++) step(1, 1'($urandom), 0, 1, 0);
    check("t032_ov", out_valid, 1);
    #3 rst = 1;
    #1;
    check("t032_rst_ov", out_valid, 0);
    check("t032_rst_data", data_o, 0);
    check("t032_rst_fill", fill_cnt, 0);
    check("t032_rst_rdy", in_ready, 0);
    bitq_m.delete(); blk_m.delete();
    last_m = '0; live_m = 0;
    @(negedge clk);
    rst = 0;
    step(0, 0, 0, 1, 0);

`ifdef DEINTERLEAVER_PINGPONG_EN
    dw = L'({$urandom, $urandom});
    bv = L'({$urandom, $urandom}) ^ 35'h1;
    for (int k = 0; k < L; k++) step(1, dw[k], 0, 1, 0);
    for (int k = 0; k < L - 1; k++) step(1, bv[k], 0, 1, 0);
    step(1, bv[L-1], 1, 1, 0);
    check("t033_ov", out_valid, 1);
    check("t033_data", data_o, deint(bv));
    step(0, 0, 1, 1, 0);
    check("t033_done", out_valid, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
